rv32_hazard_ctrl: RTL and testbench
===================================

Name: rv32_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and stall controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Resolves RAW hazards on operands entering ID/EX: forwards from EX, MEM or WB, or stalls.
- Freezes the whole pipeline while a multi-cycle data-memory load sits in MEM.
- Flushes on taken branches and keeps saturating stall/flush performance counters.

Parameters:
- NUM_RS, 2, number of source-register read ports checked in ID (2 or 3).
- LOAD_LAT, 1, cycles a load spends in MEM before its data is valid (1..8).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_rs_addr  in  NUM_RS*5  source register addresses in ID; port i at [5i+4:5i]
- id_rs_used  in  NUM_RS  port i is actually read by the ID instruction
- ex_rd  in  5  destination register in EX
- ex_regwrite  in  1  EX instruction writes rd
- ex_mem_read  in  1  EX instruction is a load
- mem_rd  in  5  destination register in MEM
- mem_regwrite  in  1  MEM instruction writes rd
- mem_mem_read  in  1  MEM instruction is a load
- wb_rd  in  5  destination register in WB
- wb_regwrite  in  1  WB instruction writes rd
- branch_taken  in  1  branch or jump resolved taken in EX
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the register
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  load a NOP into the register
- fwd_sel  out  NUM_RS*2  per port: 00 regfile, 01 EX result, 10 MEM result, 11 WB result
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1
- flush_count  out  CNT_W  count of cycles with branch-flush applied

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to IDLE; counters clear to 0.
  - All stall, flush and bubble outputs are 0, and fwd_sel is all 00, from the cycle after reset.
  - The FSM is quiescent during reset, so these outputs are 0 while rst_n=0.
  - Reset in mid-freeze aborts the freeze immediately.
- Match rule: port i matches stage S when id_rs_used[i]=1, addr!=0, addr==S_rd and S_regwrite=1.
- Priority is EX > MEM > WB (youngest producer wins).
- Memory freeze FSM (IDLE, WAIT, RELEASE):
  - freeze = (IDLE & mem_mem_read & LOAD_LAT>1) | WAIT.
  - IDLE trigger: if LOAD_LAT==2 go to RELEASE, else load cnt=LOAD_LAT-2 and go to WAIT.
  - WAIT: cnt decrements each cycle; at cnt==1 go to RELEASE. Total freeze is LOAD_LAT-1 cycles.
  - RELEASE: no freeze; load advances; go to IDLE. Back-to-back loads each freeze.
  - With LOAD_LAT=1 the FSM never leaves IDLE.
  - While frozen: pc/if_id/id_ex/ex_mem stalls=1, mem_wb_bubble=1, branch flush and load-use are suppressed (re-evaluated on release).
- Load-use: some port matches EX and ex_mem_read=1.
  - Response: pc_stall=if_id_stall=1 and id_ex_flush=1 for one cycle.
  - The load then sits in MEM, and its result is forwarded from WB (11) once it reaches WB.
  - A matching load in MEM (not frozen) also stalls one cycle the same way; no forwarding from MEM for loads.
- Branch flush (not frozen): if_id_flush=id_ex_flush=1. A simultaneous load-use stall is dropped (the ID instruction is squashed). flush_count increments.
- fwd_sel is valid only when no stall or flush is applied that cycle; otherwise it is don't-care and the bench checks 00.
- Counters saturate at all-ones. A cycle with both freeze and flush conditions counts only stall.

Optional Feature:
- Macro RV32_HAZARD_FORWARDING_EN.
- Defined: forwarding as above.
- Undefined:
  - fwd_sel is constant 0.
  - Any match on EX, MEM or WB (load or not) gives pc_stall=if_id_stall=1 and id_ex_flush=1; the register file has no write-through, so a WB match stalls.
  - Stalls repeat each cycle until no match.
  - The freeze FSM is unchanged.

Test Plan:
- add x5 in EX, ID reads rs1=x5 (forwarding on) -> fwd_sel[1:0]=01, no stall; same with x5 in MEM -> 10; in WB -> 11; x0 -> 00.
- lw x6 in EX, ID reads rs2=x6, LOAD_LAT=1 -> exactly 1 cycle pc_stall/if_id_stall/id_ex_flush; next cycle fwd_sel[3:2]=10 is illegal, so expect a stall again; then WB gives 11; stall_cycles=2.
- LOAD_LAT=4, lw enters MEM -> freeze 3 consecutive cycles (all stalls + mem_wb_bubble), then RELEASE; stall_cycles=3.
- branch_taken during cycle 2 of freeze -> no flush until release; flush on first unfrozen cycle; flush_count=1.
- Assert rst_n=0 in WAIT cycle 2 of LOAD_LAT=8 -> next cycle all outputs 0, FSM IDLE, counters 0.
- Forwarding macro off, add x7 in EX, ID reads x7 -> stall 3 cycles (EX, MEM, WB), then released with fwd_sel=0.

Source files
------------

// File: rtl/rv32_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_hazard_ctrl
//  Brief    : Hazard, forwarding and stall controller for the 5-stage RV32
//             pipeline. Resolves RAW hazards on operands entering ID/EX by
//             forwarding or stalling, freezes the pipeline while a
//             multi-cycle load sits in MEM, flushes on taken branches and
//             keeps saturating stall/flush counters.
//  Options  : RV32_HAZARD_FORWARDING_EN - when defined, operands are bypassed
//             from EX/MEM/WB; when undefined every producer match stalls and
//             fwd_sel is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32_hazard_ctrl #(
  parameter int NUM_RS   = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_RS*5-1:0]   id_rs_addr,
  input  logic [NUM_RS-1:0]     id_rs_used,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_regwrite,
  input  logic                  ex_mem_read,
  input  logic [4:0]            mem_rd,
  input  logic                  mem_regwrite,
  input  logic                  mem_mem_read,
  input  logic [4:0]            wb_rd,
  input  logic                  wb_regwrite,
  input  logic                  branch_taken,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_bubble,
  output logic [NUM_RS*2-1:0]   fwd_sel,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  // Freeze FSM encoding
  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_WAIT    = 2'd1;
  localparam logic [1:0] c_RELEASE = 2'd2;

  // A load only freezes the pipe when it needs more than one MEM cycle
  localparam bit         c_MULTI_CYCLE = (LOAD_LAT > 1);
  localparam bit         c_LAT_TWO     = (LOAD_LAT == 2);
  // Remaining WAIT cycles after the IDLE trigger cycle (only used when > 2)
  localparam logic [2:0] c_CNT_INIT    = (LOAD_LAT > 2) ? 3'(LOAD_LAT - 2) : 3'd1;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic                w_freeze;
  logic                w_branch;
  logic                w_hazard;
  logic                w_flush_apply;
  logic [NUM_RS-1:0]   w_hit_ex;
  logic [NUM_RS-1:0]   w_hit_mem;
  logic [NUM_RS-1:0]   w_hit_wb;
  logic [NUM_RS-1:0]   w_port_hazard;
  logic [NUM_RS*2-1:0] w_fwd_raw;
  logic [CNT_W-1:0]    r_stall_cycles;
  logic [CNT_W-1:0]    r_flush_count;

  // --------------------------------------------------------------------------
  // Per-port producer matching, hazard detection and bypass selection
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_RS; i++) begin : g_port
    logic [4:0] w_addr;
    logic       w_live;

    assign w_addr       = id_rs_addr[5*i +: 5];
    assign w_live       = id_rs_used[i] && (w_addr != 5'd0);
    assign w_hit_ex[i]  = w_live && ex_regwrite  && (w_addr == ex_rd);
    assign w_hit_mem[i] = w_live && mem_regwrite && (w_addr == mem_rd);
    assign w_hit_wb[i]  = w_live && wb_regwrite  && (w_addr == wb_rd);

`ifdef RV32_HAZARD_FORWARDING_EN
    // Youngest producer wins; load data is not bypassable until it is in WB
    assign w_port_hazard[i] = (w_hit_ex[i] && ex_mem_read) ||
                              (!w_hit_ex[i] && w_hit_mem[i] && mem_mem_read);
    assign w_fwd_raw[2*i +: 2] = w_hit_ex[i]  ? 2'b01 :
                                 w_hit_mem[i] ? 2'b10 :
                                 w_hit_wb[i]  ? 2'b11 : 2'b00;
`else
    // No bypass network and no regfile write-through: any producer stalls
    assign w_port_hazard[i]    = w_hit_ex[i] || w_hit_mem[i] || w_hit_wb[i];
    assign w_fwd_raw[2*i +: 2] = 2'b00;
`endif
  end : g_port

`ifndef RV32_HAZARD_FORWARDING_EN
  // The EX load flag only matters when bypassing is available
  logic w_unused_ex_load;
  assign w_unused_ex_load = ex_mem_read;
`endif

  // --------------------------------------------------------------------------
  // Freeze FSM
  // --------------------------------------------------------------------------

  // State register: reset aborts any freeze in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: a multi-cycle load in MEM freezes for LOAD_LAT-1 cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_IDLE: begin
        if (mem_mem_read && c_MULTI_CYCLE) begin
          if (c_LAT_TWO) begin
            w_state_nxt = c_RELEASE;
          end else begin
            w_state_nxt = c_WAIT;
            w_cnt_nxt   = c_CNT_INIT;
          end
        end
      end
      c_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_state_nxt = c_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      c_RELEASE: begin
        w_state_nxt = c_IDLE;
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // FSM output: freeze asserts on the trigger cycle and every WAIT cycle
  always_comb begin
    w_freeze = 1'b0;
    if (rst_n) begin
      w_freeze = ((r_state == c_IDLE) && mem_mem_read && c_MULTI_CYCLE) ||
                 (r_state == c_WAIT);
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline control: freeze > branch flush > data hazard > forwarding
  // --------------------------------------------------------------------------
  assign w_branch      = rst_n && branch_taken;
  assign w_hazard      = rst_n && (|w_port_hazard);
  assign w_flush_apply = w_branch && !w_freeze;

  // Resolve the control outputs; fwd_sel only carries meaning on clean cycles
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    fwd_sel       = '0;
    if (w_freeze) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (w_branch) begin
      // The ID instruction is squashed, so any pending load-use is moot
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_hazard) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (rst_n) begin
      fwd_sel = w_fwd_raw;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------

  // Count stalled cycles and applied branch flushes, holding at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (pc_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
      end
      if (w_flush_apply && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + c_CNT_ONE;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule : rv32_hazard_ctrl
`default_nettype wire

// File: tb/tb_rv32_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32_hazard_ctrl
//  Brief    : Directed self-checking bench for rv32_hazard_ctrl. Three
//             instances share the stimulus: LOAD_LAT=1 (2-bit counters),
//             LOAD_LAT=4 and LOAD_LAT=8. Expectations follow the build mode
//             selected by RV32_HAZARD_FORWARDING_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_hazard_ctrl;

  // Control vector layout: {pc, if_id, id_ex, ex_mem stall, if_id, id_ex flush, bubble}
  localparam logic [15:0] NONE = 16'b0000000;
  localparam logic [15:0] LU   = 16'b1100010;
  localparam logic [15:0] FRZ  = 16'b1111001;
  localparam logic [15:0] BR   = 16'b0000110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_regwrite, ex_mem_read, mem_regwrite, mem_mem_read;
  logic        wb_regwrite, branch_taken;

  logic [2:0]  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic [2:0]  if_id_flush, id_ex_flush, mem_wb_bubble;
  logic [3:0]  fwd1, fwd4, fwd8;
  logic [1:0]  sc1, fc1;
  logic [15:0] sc4, fc4, sc8, fc8;

  int checks;
  int errors;

  always #5 clk = ~clk;

  rv32_hazard_ctrl #(.NUM_RS(2), .LOAD_LAT(1), .CNT_W(2)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .pc_stall(pc_stall[0]), .if_id_stall(if_id_stall[0]), .id_ex_stall(id_ex_stall[0]),
    .ex_mem_stall(ex_mem_stall[0]), .if_id_flush(if_id_flush[0]),
    .id_ex_flush(id_ex_flush[0]), .mem_wb_bubble(mem_wb_bubble[0]),
    .fwd_sel(fwd1), .stall_cycles(sc1), .flush_count(fc1));

  rv32_hazard_ctrl #(.NUM_RS(2), .LOAD_LAT(4), .CNT_W(16)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .pc_stall(pc_stall[1]), .if_id_stall(if_id_stall[1]), .id_ex_stall(id_ex_stall[1]),
    .ex_mem_stall(ex_mem_stall[1]), .if_id_flush(if_id_flush[1]),
    .id_ex_flush(id_ex_flush[1]), .mem_wb_bubble(mem_wb_bubble[1]),
    .fwd_sel(fwd4), .stall_cycles(sc4), .flush_count(fc4));

  rv32_hazard_ctrl #(.NUM_RS(2), .LOAD_LAT(8), .CNT_W(16)) u_lat8 (
    .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .pc_stall(pc_stall[2]), .if_id_stall(if_id_stall[2]), .id_ex_stall(id_ex_stall[2]),
    .ex_mem_stall(ex_mem_stall[2]), .if_id_flush(if_id_flush[2]),
    .id_ex_flush(id_ex_flush[2]), .mem_wb_bubble(mem_wb_bubble[2]),
    .fwd_sel(fwd8), .stall_cycles(sc8), .flush_count(fc8));

  function automatic logic [15:0] outs(input int k);
    return {9'd0, pc_stall[k], if_id_stall[k], id_ex_stall[k], ex_mem_stall[k],
            if_id_flush[k], id_ex_flush[k], mem_wb_bubble[k]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs_addr   = '0;
    id_rs_used   = '0;
    ex_rd        = '0;
    ex_regwrite  = 1'b0;
    ex_mem_read  = 1'b0;
    mem_rd       = '0;
    mem_regwrite = 1'b0;
    mem_mem_read = 1'b0;
    wb_rd        = '0;
    wb_regwrite  = 1'b0;
    branch_taken = 1'b0;
  endtask

  // Move to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    // ---- Reset: outputs quiet while rst_n=0 even with hazards present ----
    rst_n = 1'b0;
    clr();
    mem_mem_read = 1'b1; branch_taken = 1'b1;
    ex_rd = 5'd5; ex_regwrite = 1'b1; ex_mem_read = 1'b1;
    id_rs_used = 2'b01; id_rs_addr = {5'd0, 5'd5};
    @(negedge clk);
    check("rst_hold_lat4", outs(1), NONE);
    check("rst_hold_lat1", outs(0), NONE);
    check("rst_hold_fwd", {12'd0, fwd1}, 16'd0);
    step();
    rst_n = 1'b1;
    clr();
    @(negedge clk);
    check("post_rst_lat8", outs(2), NONE);
    check("post_rst_sc8", sc8, 16'd0);
    check("post_rst_fc8", fc8, 16'd0);
    step();

    // ---- Producer in EX / MEM / WB ----
`ifdef RV32_HAZARD_FORWARDING_EN
    id_rs_used = 2'b01; id_rs_addr = {5'd0, 5'd5};
    ex_rd = 5'd5; ex_regwrite = 1'b1;
    @(negedge clk);
    check("fwd_ex_ctl", outs(0), NONE);
    check("fwd_ex_sel", {12'd0, fwd1}, 16'h0001);
    step();
    ex_regwrite = 1'b0; mem_rd = 5'd5; mem_regwrite = 1'b1;
    @(negedge clk);
    check("fwd_mem_ctl", outs(0), NONE);
    check("fwd_mem_sel", {12'd0, fwd1}, 16'h0002);
    step();
    mem_regwrite = 1'b0; wb_rd = 5'd5; wb_regwrite = 1'b1;
    @(negedge clk);
    check("fwd_wb_ctl", outs(0), NONE);
    check("fwd_wb_sel", {12'd0, fwd1}, 16'h0003);
    step();
    ex_rd = 5'd5; ex_regwrite = 1'b1; mem_rd = 5'd5; mem_regwrite = 1'b1;
    @(negedge clk);
    check("fwd_prio_ex", {12'd0, fwd1}, 16'h0001);
    step();
    ex_regwrite = 1'b0;
    @(negedge clk);
    check("fwd_prio_mem", {12'd0, fwd1}, 16'h0002);
    step();
    clr();
    id_rs_used = 2'b10; id_rs_addr = {5'd5, 5'd0}; ex_rd = 5'd5; ex_regwrite = 1'b1;
    @(negedge clk);
    check("fwd_port1_sel", {12'd0, fwd1}, 16'h0004);
    step();
    id_rs_used = 2'b00;
    @(negedge clk);
    check("fwd_unused_sel", {12'd0, fwd1}, 16'h0000);
    step();
`else
    id_rs_used = 2'b01; id_rs_addr = {5'd0, 5'd7};
    ex_rd = 5'd7; ex_regwrite = 1'b1;
    @(negedge clk);
    check("nofwd_ex_ctl", outs(0), LU);
    step();
    ex_regwrite = 1'b0; mem_rd = 5'd7; mem_regwrite = 1'b1;
    @(negedge clk);
    check("nofwd_mem_ctl", outs(0), LU);
    step();
    mem_regwrite = 1'b0; wb_rd = 5'd7; wb_regwrite = 1'b1;
    @(negedge clk);
    check("nofwd_wb_ctl", outs(0), LU);
    step();
    wb_regwrite = 1'b0;
    @(negedge clk);
    check("nofwd_release_ctl", outs(0), NONE);
    check("nofwd_release_sel", {12'd0, fwd1}, 16'h0000);
    step();
`endif
    // x0 is never a hazard
    clr();
    id_rs_used = 2'b01; id_rs_addr = 10'd0; ex_rd = 5'd0; ex_regwrite = 1'b1;
    @(negedge clk);
    check("x0_ctl", outs(0), NONE);
    check("x0_sel", {12'd0, fwd1}, 16'h0000);
    step();

    // ---- Load-use with LOAD_LAT=1 ----
    do_reset();
    id_rs_used = 2'b10; id_rs_addr = {5'd6, 5'd0};
    ex_rd = 5'd6; ex_regwrite = 1'b1; ex_mem_read = 1'b1;
    @(negedge clk);
    check("lu_ex_ctl", outs(0), LU);
    check("lu_ex_sel", {12'd0, fwd1}, 16'h0000);
    step();
    ex_regwrite = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd6; mem_regwrite = 1'b1; mem_mem_read = 1'b1;
    @(negedge clk);
    check("lu_mem_ctl", outs(0), LU);
    step();
    mem_regwrite = 1'b0; mem_mem_read = 1'b0; wb_rd = 5'd6; wb_regwrite = 1'b1;
    @(negedge clk);
`ifdef RV32_HAZARD_FORWARDING_EN
    check("lu_wb_ctl", outs(0), NONE);
    check("lu_wb_sel", {12'd0, fwd1}, 16'h000C);
`else
    check("lu_wb_ctl", outs(0), LU);
    check("lu_wb_sel", {12'd0, fwd1}, 16'h0000);
`endif
    step();
    clr();
    @(negedge clk);
`ifdef RV32_HAZARD_FORWARDING_EN
    check("lu_stall_cycles", {14'd0, sc1}, 16'd2);
`else
    check("lu_stall_cycles", {14'd0, sc1}, 16'd3);
`endif
    step();

    // ---- Branch squashes a simultaneous load-use ----
    id_rs_used = 2'b01; id_rs_addr = {5'd0, 5'd6};
    ex_rd = 5'd6; ex_regwrite = 1'b1; ex_mem_read = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    check("br_over_lu_ctl", outs(0), BR);
    step();
    clr();
    @(negedge clk);
    check("br_flush_count", {14'd0, fc1}, 16'd1);
    step();

    // ---- LOAD_LAT=4 freeze with branch arriving mid-freeze ----
    do_reset();
    mem_rd = 5'd9; mem_regwrite = 1'b1; mem_mem_read = 1'b1;
    @(negedge clk);
    check("frz4_c1", outs(1), FRZ);
    step();
    branch_taken = 1'b1;
    @(negedge clk);
    check("frz4_c2_br", outs(1), FRZ);
    step();
    @(negedge clk);
    check("frz4_c3_br", outs(1), FRZ);
    step();
    @(negedge clk);
    check("frz4_release_br", outs(1), BR);
    check("frz4_stall_cycles", sc4, 16'd3);
    check("frz4_flush_pre", fc4, 16'd0);
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    check("frz4_back2back", outs(1), FRZ);
    check("frz4_flush_count", fc4, 16'd1);
    step();

    // ---- LOAD_LAT=8: reset during WAIT, then a full freeze ----
    do_reset();
    mem_mem_read = 1'b1;
    @(negedge clk);
    check("frz8_c1", outs(2), FRZ);
    step();
    @(negedge clk);
    check("frz8_c2", outs(2), FRZ);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("frz8_rst_in_wait", outs(2), NONE);
    step();
    rst_n = 1'b1;
    clr();
    @(negedge clk);
    check("frz8_after_rst", outs(2), NONE);
    check("frz8_after_rst_sc", sc8, 16'd0);
    check("frz8_after_rst_fc", fc8, 16'd0);
    step();
    mem_mem_read = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("frz8_full_%0d", i), outs(2), FRZ);
      step();
    end
    @(negedge clk);
    check("frz8_release", outs(2), NONE);
    step();
    clr();
    @(negedge clk);
    check("frz8_stall_cycles", sc8, 16'd7);
    step();

    // ---- Counter saturation on 2-bit counters ----
    do_reset();
    branch_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("sat_br_%0d", i), outs(0), BR);
      step();
    end
    clr();
    id_rs_used = 2'b01; id_rs_addr = {5'd0, 5'd6};
    ex_rd = 5'd6; ex_regwrite = 1'b1; ex_mem_read = 1'b1;
    @(negedge clk);
    check("sat_flush_count", {14'd0, fc1}, 16'd3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sat_lu_%0d", i), outs(0), LU);
      step();
      @(negedge clk);
    end
    step();
    clr();
    @(negedge clk);
    check("sat_stall_cycles", {14'd0, sc1}, 16'd3);
    check("sat_flush_hold", {14'd0, fc1}, 16'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rv32_hazard_ctrl
`default_nettype wire
